spi_shift_engine: RTL and testbench

- SPI master shift engine sitting directly downstream of the SPI clock generator.
- Consumes the divided clock level produced in the clk_i domain and uses its transitions as half-period ticks to drive SCLK, MOSI and CS_n and to sample MISO.
- Also drives the generator's enable.
- Accepts one word per transaction over a valid/ready handshake and returns the received word with a single-cycle valid pulse.

---
 rtl/spi_shift_engine_pkg.sv | 18 +
 rtl/spi_edge_detect.sv | 23 ++
 rtl/spi_shift_engine.sv | 197 +++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_engine_pkg.sv
// rtl/spi_shift_engine_pkg.sv - shared state encoding and sizing helpers for the SPI shift engine
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  localparam int unsigned DEF_CS_SETUP_TICKS = 1;
  localparam int unsigned DEF_CS_HOLD_TICKS  = 1;

  function automatic int unsigned edge_cnt_width(input int unsigned data_width);
    return $clog2(2 * data_width);
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// rtl/spi_edge_detect.sv - half-period tick generator from the divided SPI clock level
module spi_edge_detect (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic en_i,
  input  logic spi_clk_i,
  output logic tick_o
);

  logic spi_clk_prev_q;
  logic spi_clk_prev_d;

  // Forced low while disabled so the generator's starting level never fakes a tick.
  always_comb spi_clk_prev_d = en_i ? spi_clk_i : 1'b0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) spi_clk_prev_q <= 1'b0;
    else           spi_clk_prev_q <= spi_clk_prev_d;
  end

  assign tick_o = en_i & (spi_clk_i ^ spi_clk_prev_q);

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master shift engine driven by ticks from the SPI clock generator
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CS_SETUP_TICKS = DEF_CS_SETUP_TICKS,
  parameter int unsigned CS_HOLD_TICKS  = DEF_CS_HOLD_TICKS
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_first_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_clk_en_o,
  input  logic                  spi_clk_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o
);

  localparam int unsigned EW     = edge_cnt_width(DATA_WIDTH);
  localparam int unsigned MAX_CS = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
  localparam int unsigned CW     = $clog2(MAX_CS + 1);

  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_WIDTH - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_TICKS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  clk_en_q, clk_en_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tick;

  logic                  tx_head;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_in;

  spi_edge_detect u_edge_detect (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .en_i      (clk_en_q),
    .spi_clk_i (spi_clk_i),
    .tick_o    (tick)
  );

  // Both shift registers move toward the end the first bit leaves from.
  assign tx_head = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_WIDTH-1];
  assign tx_next = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign rx_in   = lsb_q ? {miso_i, rx_sr_q[DATA_WIDTH-1:1]} : {rx_sr_q[DATA_WIDTH-2:0], miso_i};

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    edge_d     = edge_q;
    cnt_d      = cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    clk_en_d   = clk_en_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d   = cpol_i;
        cs_n_d   = 1'b1;
        clk_en_d = 1'b0;
        if (tx_valid_i) begin
          cpol_d   = cpol_i;
          cpha_d   = cpha_i;
          lsb_d    = lsb_first_i;
          cs_n_d   = 1'b0;
          clk_en_d = 1'b1;
          cnt_d    = '0;
          rx_sr_d  = '0;
          if (cpha_i) begin
            tx_sr_d = tx_data_i;
          end else begin
            mosi_d  = lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];
            tx_sr_d = lsb_first_i ? (tx_data_i >> 1) : (tx_data_i << 1);
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d   = '0;
            edge_d  = '0;
            state_d = ST_SHIFT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          // Sampling edges are even for CPHA=0 and odd for CPHA=1; the others shift.
          if (edge_q[0] == cpha_q) begin
            rx_sr_d = rx_in;
          end else if (edge_q != LAST_EDGE) begin
            mosi_d  = tx_head;
            tx_sr_d = tx_next;
          end
          if (edge_q == LAST_EDGE) begin
            edge_d  = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        sclk_d = cpol_q;
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d      = '0;
            cs_n_d     = 1'b1;
            clk_en_d   = 1'b0;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      cnt_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      clk_en_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      clk_en_q   <= clk_en_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready_o   = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign spi_clk_en_o = clk_en_q;
  assign sclk_o       = sclk_q;
  assign mosi_o       = mosi_q;
  assign cs_n_o       = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - randomized scoreboard bench with SPI slave and clock generator models
`timescale 1ns/1ps
module tb_spi_shift_engine;

  localparam int DW    = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 3;

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] sl;
    bit            cpol;
    bit            cpha;
    bit            lsb;
  } txn_t;

  logic          clk_i = 1'b0;
  logic          arst_n_i;
  logic          cpol_i, cpha_i, lsb_first_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          busy_o;
  logic          spi_clk_en_o;
  logic          spi_clk_i = 1'b0;
  logic          sclk_o;
  logic          mosi_o;
  logic          miso_i = 1'b0;
  logic          cs_n_o;

  spi_shift_engine #(
    .DATA_WIDTH     (DW),
    .CS_SETUP_TICKS (SETUP),
    .CS_HOLD_TICKS  (HOLD)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .cpol_i       (cpol_i),
    .cpha_i       (cpha_i),
    .lsb_first_i  (lsb_first_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .busy_o       (busy_o),
    .spi_clk_en_o (spi_clk_en_o),
    .spi_clk_i    (spi_clk_i),
    .sclk_o       (sclk_o),
    .mosi_o       (mosi_o),
    .miso_i       (miso_i),
    .cs_n_o       (cs_n_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int ratio = 2;
  int gcnt = 0;
  int tcnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int sent = 0;

  txn_t spi_q[$];
  txn_t rx_q[$];

  txn_t          cur;
  bit            sl_act = 0;
  bit            rdy_bad = 0;
  logic          cs_prev = 1'b1;
  logic          sclk_prev = 1'b0;
  logic          rxv_prev = 1'b0;
  logic [DW-1:0] mosi_word = '0;
  int            nin = 0, nout = 0, edges = 0;
  int            t_fall = 0, t_first = 0, t_last = 0;
  int            rise_cyc = 0, last_gap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not expected or bound expired", nm);
  endtask

  function automatic logic seq_bit(input logic [DW-1:0] w, input int k, input bit lsb);
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  // SPI slave, protocol checker and clock generator share one process so tick counts line up.
  always @(negedge clk_i) begin
    cyc++;
    if (!arst_n_i) begin
      sl_act = 0;
      miso_i = 1'b0;
    end else if (!sl_act) begin
      if (cs_prev && !cs_n_o) begin
        last_gap = cyc - rise_cyc;
        if (spi_q.size() == 0) begin
          fail("cs_fall_without_request");
        end else begin
          cur       = spi_q.pop_front();
          sl_act    = 1;
          nin       = 0;
          nout      = 0;
          edges     = 0;
          rdy_bad   = 0;
          mosi_word = '0;
          t_fall    = tcnt;
          chk("sclk_at_cs_fall", 32'(sclk_o), 32'(cur.cpol));
          if (!cur.cpha) begin
            miso_i = seq_bit(cur.sl, 0, cur.lsb);
            nout   = 1;
          end
        end
      end
    end else if (cs_n_o) begin
      chk("mosi_word", 32'(mosi_word), 32'(cur.tx));
      chk("sclk_edges", edges, 2 * DW);
      chk("setup_ticks", t_first - t_fall - 1, SETUP);
      chk("hold_ticks", tcnt - t_last, HOLD);
      chk("sclk_at_cs_rise", 32'(sclk_o), 32'(cur.cpol));
      chk("ready_low_busy_high_in_txn", 32'(rdy_bad), 0);
      sl_act   = 0;
      rise_cyc = cyc;
    end else begin
      if (tx_ready_o || !busy_o) rdy_bad = 1;
      if (sclk_o != sclk_prev) begin
        edges++;
        if (edges == 1) t_first = tcnt;
        t_last = tcnt;
        if ((sclk_prev == cur.cpol) != cur.cpha) begin
          if (nin < DW) begin
            if (cur.lsb) mosi_word[nin] = mosi_o;
            else         mosi_word[DW-1-nin] = mosi_o;
          end
          nin++;
        end else if (nout < DW) begin
          miso_i = seq_bit(cur.sl, nout, cur.lsb);
          nout++;
        end
      end
    end
    cs_prev   = cs_n_o;
    sclk_prev = sclk_o;

    if (!spi_clk_en_o) begin
      spi_clk_i = 1'b0;
      gcnt      = 0;
    end else begin
      gcnt++;
      if (gcnt >= ratio) begin
        gcnt      = 0;
        spi_clk_i = ~spi_clk_i;
        tcnt++;
      end
    end
  end

  always @(negedge clk_i) begin
    txn_t e;
    if (rx_valid_o) begin
      if (rxv_prev) begin
        fail("rx_valid_longer_than_one_cycle");
      end else if (rx_q.size() == 0) begin
        fail("rx_valid_unexpected");
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(rx_data_o), 32'(e.sl));
        chk("tx_ready_at_rx_valid", 32'(tx_ready_o), 1);
        done_cnt++;
      end
    end
    rxv_prev = rx_valid_o;
  end

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] s,
                      input bit pol, input bit pha, input bit lsb);
    txn_t e;
    e.tx = d; e.sl = s; e.cpol = pol; e.cpha = pha; e.lsb = lsb;
    spi_q.push_back(e);
    rx_q.push_back(e);
    sent++;
    tx_data_i   = d;
    cpol_i      = pol;
    cpha_i      = pha;
    lsb_first_i = lsb;
    tx_valid_i  = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      if (tx_ready_o) begin
        @(posedge clk_i);
        #1;
        return;
      end
    end
    fail("accept_timeout");
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 6000 && done_cnt < n; i++) @(posedge clk_i);
    if (done_cnt < n) fail("completion_timeout");
    #1;
  endtask

  initial begin
    int base;
    bit b2b;
    arst_n_i    = 1'b0;
    cpol_i      = 1'b0;
    cpha_i      = 1'b0;
    lsb_first_i = 1'b0;
    tx_data_i   = '0;
    tx_valid_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cs_n", 32'(cs_n_o), 1);
    chk("rst_sclk", 32'(sclk_o), 0);
    chk("rst_mosi", 32'(mosi_o), 0);
    chk("rst_tx_ready", 32'(tx_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rx_valid", 32'(rx_valid_o), 0);
    chk("rst_rx_data", 32'(rx_data_o), 0);
    chk("rst_clk_en", 32'(spi_clk_en_o), 0);
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    ratio = 2;
    send(8'hA5, 8'h3C, 0, 0, 0);
    tx_valid_i = 1'b0;
    wait_done(sent);

    cpol_i = 1'b1; cpha_i = 1'b1; lsb_first_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("sclk_idle_cpol1", 32'(sclk_o), 1);
    send(8'h01, 8'h80, 1, 1, 1);
    tx_valid_i = 1'b0;
    wait_done(sent);

    ratio = 1;
    send(8'h11, 8'hEE, 0, 0, 0);
    send(8'h22, 8'hDD, 0, 0, 0);
    tx_valid_i = 1'b0;
    wait_done(sent);
    chk("b2b_cs_high_cycles", last_gap, 1);

    ratio = 3;
    base  = tcnt;
    send(8'hC3, 8'h5A, 0, 1, 0);
    tx_valid_i = 1'b0;
    for (int i = 0; i < 500 && tcnt < base + 5; i++) @(posedge clk_i);
    if (tcnt < base + 5) fail("reset_tick_wait");
    #1;
    arst_n_i = 1'b0;
    sent--;
    rx_q.delete();
    spi_q.delete();
    #1;
    chk("abort_cs_n", 32'(cs_n_o), 1);
    chk("abort_sclk", 32'(sclk_o), 0);
    chk("abort_clk_en", 32'(spi_clk_en_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    send(8'h96, 8'h69, 1, 0, 1);
    tx_valid_i = 1'b0;
    wait_done(sent);

    ratio = 2;
    send(8'h3A, 8'hE7, 0, 1, 0);
    tx_valid_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    cpol_i = 1'b1; cpha_i = 1'b0; lsb_first_i = 1'b1; tx_data_i = 8'hFF;
    wait_done(sent);

    for (int i = 0; i < 12; i++) begin
      ratio = (i == 0) ? 7 : int'($urandom_range(1, 7));
      b2b   = (i != 11) && ($urandom_range(0, 3) == 0);
      send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (!b2b) begin
        tx_valid_i = 1'b0;
        wait_done(sent);
      end
    end
    tx_valid_i = 1'b0;
    wait_done(sent);
    repeat (5) @(posedge clk_i);
    chk("all_requests_completed", done_cnt, sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
